// File: rtl/operand_loader.sv
// Hex-keypad operand entry for the RK4 datapath: debounced digit/clear buttons
// shift Q16.16 words MSB-first into five operand registers, then handshake on ACK.
module operand_loader #(
  parameter int n       = 32,
  parameter int DEB_CYC = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [3:0]   SW,
  input  logic         BTN_DIG,
  input  logic         BTN_CLR,
  input  logic         LOCK,
  input  logic         ACK,
  output logic [n-1:0] X_O,
  output logic [n-1:0] Y_O,
  output logic [n-1:0] C_VAL,
  output logic [n-1:0] N_VAL,
  output logic [n-1:0] INV_N,
  output logic         VALID,
  output logic [n-1:0] SHADOW,
  output logic [2:0]   OP_IDX,
  output logic [2:0]   DIG_IDX
);

  localparam int         CW       = $clog2(DEB_CYC);
  localparam logic [2:0] LAST_DIG = 3'(n / 4 - 1);
  localparam logic [n-1:0] X_RST   = n'(32'h0000_0000);
  localparam logic [n-1:0] Y_RST   = n'(32'h0005_0000);
  localparam logic [n-1:0] C_RST   = n'(32'h0002_0000);
  localparam logic [n-1:0] N_RST   = n'(32'h000A_0000);
  localparam logic [n-1:0] INV_RST = n'(32'h0000_199A);

  typedef enum logic [1:0] {ENTRY, DONE, IDLE} state_e;

  logic [1:0] btn_raw;
  logic [1:0] rise;
  assign btn_raw = {BTN_CLR, BTN_DIG};

  // Per button: 2-flop sync, stability counter, then rising-edge detect on the debounced level.
  for (genvar b = 0; b < 2; b++) begin : g_deb
    logic          s1_q, s2_q, lvl_q, prev_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        lvl_q  <= 1'b0;
        prev_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        s1_q   <= btn_raw[b];
        s2_q   <= s1_q;
        prev_q <= lvl_q;
        if (s2_q != lvl_q) begin
          if (cnt_q == CW'(DEB_CYC - 1)) begin
            lvl_q <= s2_q;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign rise[b] = lvl_q & ~prev_q;
  end

  logic dig_ev, clr_ev;
  assign dig_ev = rise[0] & ~LOCK;
  assign clr_ev = rise[1] & ~LOCK;

  state_e       state_q;
  logic         valid_q;
  logic [n-1:0] shadow_q, shadow_d;
  logic [2:0]   op_q, dig_q;
  logic [n-1:0] x_q, y_q, c_q, nv_q, inv_q;

  assign shadow_d = {shadow_q[n-5:0], SW};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ENTRY;
      valid_q  <= 1'b0;
      shadow_q <= '0;
      op_q     <= '0;
      dig_q    <= '0;
      x_q      <= X_RST;
      y_q      <= Y_RST;
      c_q      <= C_RST;
      nv_q     <= N_RST;
      inv_q    <= INV_RST;
    end else begin
      case (state_q)
        ENTRY: begin
          if (clr_ev) begin
            shadow_q <= '0;
            dig_q    <= '0;
          end else if (dig_ev) begin
            if (dig_q == LAST_DIG) begin
              case (op_q)
                3'd0:    x_q   <= shadow_d;
                3'd1:    y_q   <= shadow_d;
                3'd2:    c_q   <= shadow_d;
                3'd3:    nv_q  <= shadow_d;
                default: inv_q <= shadow_d;
              endcase
              shadow_q <= '0;
              dig_q    <= '0;
              if (op_q == 3'd4) begin
                state_q <= DONE;
                valid_q <= 1'b1;
                op_q    <= '0;
              end else begin
                op_q <= op_q + 3'd1;
              end
            end else begin
              shadow_q <= shadow_d;
              dig_q    <= dig_q + 3'd1;
            end
          end
        end
        // ACK takes priority over a simultaneous clear.
        DONE: begin
          if (ACK) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else if (clr_ev) begin
            state_q <= ENTRY;
            valid_q <= 1'b0;
          end
        end
        IDLE: begin
          if (clr_ev) begin
            state_q  <= ENTRY;
            op_q     <= '0;
            dig_q    <= '0;
            shadow_q <= '0;
          end
        end
        default: state_q <= ENTRY;
      endcase
    end
  end

  assign X_O     = x_q;
  assign Y_O     = y_q;
  assign C_VAL   = c_q;
  assign N_VAL   = nv_q;
  assign INV_N   = inv_q;
  assign VALID   = valid_q;
  assign SHADOW  = shadow_q;
  assign OP_IDX  = op_q;
  assign DIG_IDX = dig_q;

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter n, default 32, operand width (Q16.16 fixed point).
REQ-002 SHALL have parameter DEB_CYC, default 16, debounce stability count in CLK cycles (minimum 2).
REQ-003 SHALL have port CLK  input  1  the single clock (the same slow clock that feeds the RK4 datapath).
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SW  input  4  hex digit to enter.
REQ-006 SHALL have port BTN_DIG  input  1  raw button, commits SW as the next digit.
REQ-007 SHALL have port BTN_CLR  input  1  raw button, clears entry.
REQ-008 SHALL have port LOCK  input  1  high while the RK4 run is active; button events are ignored while high.
REQ-009 SHALL have port ACK  input  1  RK4 control has consumed the operands.
REQ-010 SHALL have ports X_O, Y_O, C_VAL, N_VAL, INV_N  output  n each  loaded operands.
REQ-011 SHALL have port VALID  output  1  complete operand set ready.
REQ-012 SHALL have port SHADOW  output  n  partial word being entered (for seven-segment echo).
REQ-013 SHALL have port OP_IDX  output  3  operand being entered, 0..4.
REQ-014 SHALL have port DIG_IDX  output  3  digits entered in the current operand, 0..7.

Function
REQ-015 SHALL pass each raw button through a 2-flop synchronizer.
REQ-016 SHALL update the debounced level only after the synchronized value has differed from it for DEB_CYC consecutive cycles; any mismatch-free cycle restarts the count.
REQ-017 SHALL generate a one-cycle event on each debounced 0->1 transition only; holding a button produces exactly one event.
REQ-018 SHALL discard every event generated while LOCK=1; no event is queued.
REQ-019 SHALL implement states ENTRY, DONE and IDLE.
REQ-020 ENTRY, DIG event: SHADOW <= {SHADOW[n-5:0], SW} and DIG_IDX increments, taking effect at the edge following the event.
REQ-021 ENTRY, eighth DIG event: the operand register selected by OP_IDX (0=X_O, 1=Y_O, 2=C_VAL, 3=N_VAL, 4=INV_N) SHALL be written with the completed word, and on the same edge SHADOW and DIG_IDX SHALL clear to 0.
REQ-022 After REQ-021, OP_IDX SHALL increment; if OP_IDX was 4, the block SHALL instead enter DONE with VALID=1 and OP_IDX=0.
REQ-023 ENTRY, CLR event: SHADOW and DIG_IDX SHALL clear; OP_IDX and the operand registers are unchanged.
REQ-024 DONE: VALID SHALL stay 1 until ACK=1 is sampled.
REQ-025 DONE, ACK=1: the block SHALL move to IDLE with VALID=0 on the next edge.
REQ-026 DONE, CLR event (LOCK=0): the block SHALL go to ENTRY with VALID=0.
REQ-027 IDLE: DIG events are ignored; a CLR event SHALL move the block to ENTRY with OP_IDX=0, DIG_IDX=0 and SHADOW=0.
REQ-028 Operand registers SHALL retain their values until individually overwritten.
REQ-029 ACK outside DONE SHALL be ignored.
REQ-030 A DIG event and a CLR event on the same cycle: CLR SHALL win.
REQ-031 ACK=1 and a CLR event on the same cycle in DONE: ACK SHALL win.
REQ-032 No arithmetic is performed on operands; entry order is MSB digit first, exactly as shown on the display.

Reset
REQ-033 While RST=0 the block SHALL asynchronously force: state ENTRY, VALID=0, SHADOW=0, OP_IDX=0, DIG_IDX=0, synchronizers/debounce levels/counters 0.
REQ-034 Reset values of the operand registers SHALL be X_O=0x00000000, Y_O=0x00050000, C_VAL=0x00020000, N_VAL=0x000A0000, INV_N=0x0000199A.
REQ-035 Reset release SHALL take effect at the next CLK edge; a reset mid-entry SHALL discard the partial word.

Verification
REQ-036 After reset, the outputs SHALL equal the REQ-034 defaults with VALID=0; then press BTN_DIG with SW=0xA held for DEB_CYC+5 cycles -> SHADOW=0x0000000A, DIG_IDX=1, exactly one shift.
REQ-037 Enter all 40 digits, with X_O=0x00010000, Y_O=0x00030000, C_VAL=0x00040000, N_VAL=0x00140000, INV_N=0x00000CCD -> all five registers match, VALID=1, OP_IDX=0.
REQ-038 Bench SHALL pulse BTN_DIG for DEB_CYC-1 cycles, then toggle it every cycle for 20 cycles -> no digit entered.
REQ-039 Enter 5 digits, press BTN_CLR -> SHADOW=0, DIG_IDX=0, OP_IDX unchanged; then assert BTN_DIG and BTN_CLR together -> CLR result only.
REQ-040 In DONE: drive ACK=1 -> VALID=0 next edge, IDLE; with LOCK=1, press BTN_CLR -> no change; with LOCK=0, press BTN_CLR -> ENTRY with OP_IDX=0.
REQ-041 Assert RST low after 3 digits of Y_O -> SHADOW=0, OP_IDX=0, and all operands restored to the REQ-034 defaults.
